// File: rtl/sub_pkg.sv
// Shared types, constants and gate-level helpers for the bit-serial subtractor.
package sub_pkg;

    // Default operand/result width.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states: waiting for operands, shifting bits, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of bits needed to count 0 .. value-1. Never returns less than 1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Inhibition / not-implication primitive: x AND NOT y.
    function automatic logic not_impl(input logic x, input logic y);
        return x & ~y;
    endfunction

endpackage

// File: rtl/full_sub_bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_sub_bit
    import sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;
    assign d       = a_xor_b ^ bin;

    // Borrow when b exceeds a outright, or when a equals b and a borrow is
    // already pending from the lower bit.
    assign bout = not_impl(b, a) | not_impl(bin, a_xor_b);

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial subtractor: accepts a/b on a valid/ready handshake, computes
// a - b LSB-first one bit per clock, and presents diff plus the final borrow
// (set iff a < b unsigned) on an output valid/ready handshake.
module serial_sub_unit
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int            CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             bit_d;
    logic             bit_bout;
    logic             last_bit;

    // Single full subtractor shared by every bit position over time.
    full_sub_bit u_bit (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign last_bit = (cnt_q == LAST);

    // Next-state and handshake outputs; both handshake signals depend only on state.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a signal unassigned, which would infer a latch.
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: load operands in IDLE, shift one bit per RUN cycle,
    // and capture the published result only on the final RUN cycle.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d = a;
                    b_sh_d = b;
                    br_d   = 1'b0;
                    cnt_d  = '0;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {bit_d, res_q[WIDTH-1:1]};
                br_d   = bit_bout;
                cnt_d  = cnt_q + CW'(1);
                if (last_bit) begin
                    diff_d   = {bit_d, res_q[WIDTH-1:1]};
                    borrow_d = bit_bout;
                end
            end
            default: begin
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples its inputs from before this edge.
            state_q <= state_d;
        end
    end

    // Datapath registers; all cleared on reset so nothing starts as X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub_unit.sv
// Scoreboard bench for serial_sub_unit: the stimulus pushes expected
// {borrow, diff} plus the accept cycle; a negedge monitor compares.
module tb_serial_sub_unit;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    typedef struct {
        logic [WIDTH:0] exp;
        int             acc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   cyc        = 0;
    int   n_accepts  = 0;
    int   n_results  = 0;
    bit   busy       = 1'b0;
    bit   prev_ov    = 1'b0;
    bit   rand_ready = 1'b0;

    serial_sub_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair; record the expectation at the edge that accepts it.
    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH:0] ev);
        a = av;
        b = bv;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back('{exp: ev, acc: cyc + 1});
                n_accepts++;
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        fail_now("accept timeout");
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < WIDTH + 20; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        fail_now("out_valid timeout");
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) begin
                step();
                return;
            end
        end
        fail_now("drain timeout");
    endtask

    // Random consumer stalls during the random phase.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: handshake legality, latency, result value and stability.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            sb_q.delete();
            busy    = 1'b0;
            prev_ov = 1'b0;
        end else begin
            check("in_ready", in_ready, !busy);
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    fail_now("spurious out_valid");
                end else begin
                    if (!prev_ov) check("latency", cyc, sb_q[0].acc + WIDTH);
                    check("result", {borrow, diff}, sb_q[0].exp);
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        n_results++;
                        busy = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) busy = 1'b1;
            prev_ov = out_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset diff", diff, 0);
        check("reset borrow", borrow, 0);
        step();
        rst_n = 1'b1;
        step();

        // Basic, underflow and extremes with expected values written out.
        send(8'h5A, 8'h33, 9'h027);
        drain();
        send(8'h00, 8'h01, 9'h1FF);
        send(8'h00, 8'hFF, 9'h101);
        send(8'hFF, 8'hFF, 9'h000);
        send(8'hFF, 8'h00, 9'h0FF);
        drain();

        // Backpressure in DONE with in_valid pulsed while busy.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 9'h1DE);
        a = 8'h11;
        b = 8'h22;
        in_valid = 1'b1;
        wait_valid();
        repeat (5) step();
        check("stall out_valid", out_valid, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Asynchronous reset three cycles into RUN discards the operation.
        send(8'hC3, 8'h3C, 9'h087);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun in_ready", in_ready, 1);
        check("midrun out_valid", out_valid, 0);
        check("midrun diff", diff, 0);
        check("midrun borrow", borrow, 0);
        n_accepts--;
        step();
        rst_n = 1'b1;
        send(8'h80, 8'h01, 9'h07F);
        drain();

        // Random pairs against the arithmetic model with random stalls.
        rand_ready = 1'b1;
        repeat (200) begin
            repeat ($urandom_range(0, 2)) step();
            av = WIDTH'($urandom);
            bv = WIDTH'($urandom);
            send(av, bv, {1'b0, av} - {1'b0, bv});
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        check("results per accept", n_results, n_accepts);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
